top_counter: RTL and testbench

TOP_COUNTER -- requirements
Module: top_counter

---
 rtl/top_counter.sv | 67 ++++++
 tb/tb_top_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/top_counter.sv
// top_counter: loadable up/down counter with registered one-cycle
// overflow and underflow pulses. Action priority on each rising clock
// edge: LOAD, then UP, then DN, otherwise hold. RES is an asynchronous,
// active-high reset.
module top_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    input  logic             UP,
    input  logic             DN,
    output logic [WIDTH-1:0] DOUT,
    output logic             OVF,
    output logic             UDF
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    // Next-state logic. The flags are recomputed on every edge, so each
    // wrap gives a pulse that lasts exactly one cycle. Back-to-back wraps
    // therefore give back-to-back pulses.
    // DIN is used only on the LOAD branch. An unknown DIN cannot reach
    // the state while LOAD is low.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (LOAD) begin
            // A load never raises a flag, even when it loads a boundary value.
            count_d = DIN;
        end else if (UP) begin
            count_d = count_q + ONE;
            ovf_d   = (count_q == ALL_ONES);
        end else if (DN) begin
            count_d = count_q - ONE;
            udf_d   = (count_q == ZERO);
        end
    end

    // State registers. Reset forces zero and clears both flags at once,
    // without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            count_q <= ZERO;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // All outputs come straight from flops. No path from input to output.
    assign DOUT = count_q;
    assign OVF  = ovf_q;
    assign UDF  = udf_q;

endmodule

// File: tb/tb_top_counter.sv
// Self-checking bench for top_counter. It runs directed sequences and then
// randomized stimulus. A simple arithmetic reference model predicts every
// output.
module tb_top_counter;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    logic         CLK;
    logic         RES;
    logic [W-1:0] DIN;
    logic         LOAD;
    logic         UP;
    logic         DN;
    logic [W-1:0] DOUT;
    logic         OVF;
    logic         UDF;

    top_counter #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RES  (RES),
        .DIN  (DIN),
        .LOAD (LOAD),
        .UP   (UP),
        .DN   (DN),
        .DOUT (DOUT),
        .OVF  (OVF),
        .UDF  (UDF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dout"}, 32'(DOUT), 32'(m_cnt));
        check({tag, ".ovf"},  32'(OVF),  32'(m_ovf));
        check({tag, ".udf"},  32'(UDF),  32'(m_udf));
    endtask

    // Apply one action at the next rising edge. The model follows the
    // counter rules by plain integer arithmetic.
    task automatic step(input string tag, input bit l, input bit u, input bit d,
                        input logic [W-1:0] din);
        @(negedge CLK);
        LOAD = l; UP = u; DN = d; DIN = din;
        @(posedge CLK);
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (l) begin
            m_cnt = int'(din);
        end else if (u) begin
            m_ovf = (m_cnt == MAX);
            m_cnt = (m_cnt + 1) % (MAX + 1);
        end else if (d) begin
            m_udf = (m_cnt == 0);
            m_cnt = (m_cnt + MAX) % (MAX + 1);
        end
        #1;
        $display("txn %-8s L=%0b U=%0b D=%0b DIN=%h -> DOUT=%h OVF=%0b UDF=%0b",
                 tag, l, u, d, din, DOUT, OVF, UDF);
        check_outputs(tag);
        check({tag, ".excl"}, 32'(OVF & UDF), 32'd0);
    endtask

    // Pulse reset away from any clock edge and check the outputs at once.
    task automatic async_reset(input string tag);
        @(negedge CLK);
        LOAD = 1'b0; UP = 1'b1; DN = 1'b0;
        #2;
        RES = 1'b1;
        #1;
        m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
        $display("txn %-8s async reset -> DOUT=%h OVF=%0b UDF=%0b", tag, DOUT, OVF, UDF);
        check_outputs(tag);
        @(negedge CLK);
        RES = 1'b0;
        UP = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rdin;
        bit rl, ru, rd;

        RES = 1'b1; LOAD = 1'b1; UP = 1'b1; DN = 1'b0; DIN = 8'hAA;
        // Reset holds the counter at zero across clock edges, even with active inputs
        repeat (3) @(posedge CLK);
        #1;
        $display("txn reset    held -> DOUT=%h OVF=%0b UDF=%0b", DOUT, OVF, UDF);
        check_outputs("reset");
        @(negedge CLK);
        RES = 1'b0; LOAD = 1'b0; UP = 1'b0;

        // Load sequence. The first load after reset takes effect on the next edge.
        step("load01", 1, 0, 0, 8'h01);
        step("load23", 1, 0, 0, 8'h23);
        step("load45", 1, 0, 0, 8'h45);
        step("load67", 1, 0, 0, 8'h67);

        // Up / down
        step("ld00", 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step("up", 0, 1, 0, 8'h00);
        for (int i = 0; i < 2; i++) step("dn", 0, 0, 1, 8'h00);

        // Overflow
        step("ldFE", 1, 0, 0, 8'hFE);
        for (int i = 0; i < 4; i++) step("ovf_up", 0, 1, 0, 8'h00);

        // Underflow
        step("ld02", 1, 0, 0, 8'h02);
        for (int i = 0; i < 4; i++) step("udf_dn", 0, 0, 1, 8'h00);

        // Loads of boundary values raise no flag
        step("ldFF", 1, 0, 0, 8'hFF);
        step("ldFFu", 1, 1, 0, 8'h00);
        step("ld00d", 1, 0, 1, 8'hFF);

        // Consecutive wraps: FF -> 00 -> FF -> 00
        step("ldFF2", 1, 0, 0, 8'hFF);
        step("wrapup", 0, 1, 0, 8'h00);
        step("wrapdn", 0, 0, 1, 8'h00);
        step("wrapup2", 0, 1, 0, 8'h00);

        // Conflicting controls
        step("c_lud", 1, 1, 1, 8'h12);
        step("c_ld",  1, 0, 1, 8'h34);
        step("c_lu",  1, 1, 0, 8'h56);
        step("c_ud",  0, 1, 1, 8'hxx);
        step("c_d",   0, 0, 1, 8'hxx);
        step("hold",  0, 0, 0, 8'hxx);
        step("to57",  0, 1, 0, 8'h00);

        // Asynchronous reset with DOUT = 0x57
        check("pre_rst", 32'(DOUT), 32'h57);
        async_reset("rst57");
        step("post_rst", 0, 1, 0, 8'h00);

        // Reset in the middle of an overflow pulse
        step("ldFF3", 1, 0, 0, 8'hFF);
        step("ovf_p", 0, 1, 0, 8'h00);
        async_reset("rst_ovf");

        // Randomized stimulus. DIN is unknown whenever LOAD is low.
        for (int i = 0; i < 400; i++) begin
            rl = ($urandom_range(0, 7) == 0);
            ru = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            rdin = rl ? W'($urandom) : 'x;
            if ($urandom_range(0, 15) == 0) rdin = rl ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00) : 'x;
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            else step("rnd", rl, ru, rd, rdin);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
